// File: rtl/timer_multi.sv
// timer_multi
//   Multi-channel sample-wait timer on the CPU byte bus. Each channel counts
//   down a 16-bit number of sample periods. Every channel owns a fractional-N
//   accumulator, so ticks arrive at an exact average rate of FS per CLK clocks.
//   Channels run one-shot or periodic. A per-channel done flag, gated by ien,
//   feeds a shared irq.
//
// Ports
//   clk    : system clock
//   rst    : synchronous reset, active-high
//   wr     : register write strobe, one cycle
//   adr    : adr[AW-1:2] selects the channel, adr[1:0] selects the register
//            (0 CNTL, 1 CNTH, 2 CTRL, 3 STAT)
//   data   : write data
//   rdata  : read data, combinational from adr (00 for channels >= CH)
//   active : per channel, count != 0
//   irq    : OR over channels of (done & ien)
module timer_multi #(
    parameter int unsigned CLK = 3579545,
    parameter int unsigned FS  = 44100,
    parameter int unsigned CH  = 2,
    parameter int unsigned AW  = $clog2(CH) + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [AW-1:0] adr,
    input  logic [7:0]    data,
    output logic [7:0]    rdata,
    output logic [CH-1:0] active,
    output logic          irq
);

    localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned ACCW = $clog2(CLK) + 1;
    localparam logic [ACCW-1:0] FS_W  = ACCW'(FS);
    localparam logic [ACCW-1:0] CLK_W = ACCW'(CLK);

    logic [15:0]     count  [CH];
    logic [15:0]     reload [CH];
    logic [ACCW-1:0] acc    [CH];
    logic [ACCW-1:0] acc_sum[CH];
    logic [CH-1:0]   en;
    logic [CH-1:0]   periodic;
    logic [CH-1:0]   ien;
    logic [CH-1:0]   done;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   wsel;
    logic [CW-1:0]   ch_sel;

    // With a single channel there are no channel address bits at all.
    generate
        if (CH == 1) begin : g_sel_one
            assign ch_sel = '0;
        end else begin : g_sel_multi
            assign ch_sel = adr[AW-1:2];
        end
    endgenerate

    // acc stays below CLK, so acc + FS < 2*CLK fits in ACCW bits without overflow.
    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            active[i]  = (count[i] != '0);
            acc_sum[i] = acc[i] + FS_W;
            tick[i]    = en[i] && (count[i] != '0) && (acc_sum[i] >= CLK_W);
            wsel[i]    = wr && (ch_sel == CW'(i));
        end
    end

    assign irq = |(done & ien);

    // Channel indices >= CH never match, so reads of them return 00.
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (ch_sel == CW'(i)) begin
                case (adr[1:0])
                    2'd0:    rdata = count[i][7:0];
                    2'd1:    rdata = count[i][15:8];
                    2'd2:    rdata = {5'b0, done[i], ien[i], periodic[i]};
                    default: rdata = {7'b0, done[i]};
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CH; i++) begin
                count[i]  <= '0;
                reload[i] <= '0;
                acc[i]    <= '0;
            end
            en       <= '0;
            periodic <= '0;
            ien      <= '0;
            done     <= '0;
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                if (wsel[i] && adr[1:0] == 2'd2) begin
                    periodic[i] <= data[0];
                    ien[i]      <= data[1];
                end
                // Clear comes first so that a terminal tick in the same cycle,
                // assigned below, leaves done set.
                if (wsel[i] && adr[1:0] == 2'd3 && data[0])
                    done[i] <= 1'b0;

                // Count-register writes replace count/acc outright and drop any
                // tick of this cycle.
                if (wsel[i] && adr[1:0] == 2'd0) begin
                    en[i]           <= 1'b0;
                    count[i][7:0]   <= data;
                    reload[i][7:0]  <= data;
                end else if (wsel[i] && adr[1:0] == 2'd1) begin
                    en[i]           <= 1'b1;
                    acc[i]          <= '0;
                    count[i][15:8]  <= data;
                    reload[i][15:8] <= data;
                end else if (tick[i]) begin
                    acc[i] <= acc_sum[i] - CLK_W;
                    if (count[i] == 16'd1) begin
                        done[i]  <= 1'b1;
                        count[i] <= periodic[i] ? reload[i] : '0;
                    end else begin
                        count[i] <= count[i] - 16'd1;
                    end
                end else if (en[i] && count[i] != '0) begin
                    acc[i] <= acc_sum[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_multi.sv
// tb_timer_multi
//   Scoreboard bench for timer_multi. Stimulus pushes expected observations
//   into a queue; a monitor on the falling clock edge pops and compares them.
//   dut uses CLK=10, FS=3 for cycle-exact sequences; dut2 uses default
//   parameters for the long 10 ms one-shot.
module tb_timer_multi;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wr, wr2;
    logic [2:0] adr, adr2;
    logic [7:0] data, data2, rdata, rdata2;
    logic [1:0] active, active2;
    logic       irq, irq2;

    timer_multi #(.CLK(10), .FS(3), .CH(2)) dut (
        .clk(clk), .rst(rst), .wr(wr), .adr(adr), .data(data),
        .rdata(rdata), .active(active), .irq(irq)
    );

    timer_multi #(.CH(2)) dut2 (
        .clk(clk), .rst(rst), .wr(wr2), .adr(adr2), .data(data2),
        .rdata(rdata2), .active(active2), .irq(irq2)
    );

    // kind: 0 rdata, 1 active, 2 irq, 3 rdata2, 4 long-count length in range,
    //       5 irq2, 6 active2
    typedef struct {
        string      name;
        int         kind;
        logic [7:0] exp;
    } item_t;

    item_t      q[$];
    item_t      m_it;
    logic [7:0] m_obs;
    int         n_cmp = 0;
    int         n_mis = 0;
    int         cyc = 0;
    int         e0 = 0;
    int         t2_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_it = q.pop_front();
            case (m_it.kind)
                0:       m_obs = rdata;
                1:       m_obs = {6'b0, active};
                2:       m_obs = {7'b0, irq};
                3:       m_obs = rdata2;
                4:       m_obs = {7'b0, (t2_len >= 35796 && t2_len <= 35798)};
                5:       m_obs = {7'b0, irq2};
                default: m_obs = {6'b0, active2};
            endcase
            n_cmp++;
            if (m_obs !== m_it.exp) begin
                n_mis++;
                $display("FAIL %s: got %h, required %h (t=%0t, t2_len=%0d)",
                         m_it.name, m_obs, m_it.exp, $time, t2_len);
            end
        end
    end

    task automatic push(input int kind, input logic [7:0] exp, input string name);
        q.push_back('{name, kind, exp});
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
        adr = a;
        push(0, exp, name);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        adr  = a;
        data = d;
        wr   = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    // Position just after clock edge e0+k.
    task automatic at_after(input int k);
        while (cyc < e0 + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required normal finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr = 1'b0; wr2 = 1'b0;
        adr = '0; adr2 = '0; data = '0; data2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        push(1, 8'h00, "rst_active");
        push(2, 8'h00, "rst_irq");
        push(3, 8'h00, "rst_dut2_cntl");
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 8'h00, "rst_read");
            sample();
        end

        // T1: count 2 one-shot, ticks at edges 4 and 7
        wr_reg(3'b000, 8'd2);
        wr_reg(3'b001, 8'd0);
        e0 = cyc;
        rd(3'b000, 8'd2, "t1_cnt_k0"); push(1, 8'h01, "t1_active_k0"); sample();
        at_after(3); rd(3'b000, 8'd2, "t1_cnt_k3"); sample();
        at_after(4); rd(3'b000, 8'd1, "t1_cnt_k4"); sample();
        at_after(6); rd(3'b000, 8'd1, "t1_cnt_k6"); push(1, 8'h01, "t1_active_k6"); sample();
        at_after(7); rd(3'b000, 8'd0, "t1_cnt_k7"); push(1, 8'h00, "t1_active_k7"); sample();
        at_after(8); rd(3'b011, 8'h01, "t1_done"); push(2, 8'h00, "t1_irq_masked"); sample();
        at_after(9); rd(3'b010, 8'h04, "t1_ctrl"); sample();
        wr_reg(3'b011, 8'h01);
        rd(3'b011, 8'h00, "t1_stat_clr"); sample();

        // T3/T5: periodic count 3 with irq, ticks at 4,7,10,14,17,20,24,27,30
        wr_reg(3'b010, 8'h03);
        wr_reg(3'b000, 8'd3);
        wr_reg(3'b001, 8'd0);
        e0 = cyc;
        at_after(9);  rd(3'b000, 8'd1, "t3_cnt_k9");  push(2, 8'h00, "t3_irq_k9");  sample();
        at_after(10); rd(3'b000, 8'd3, "t3_reload_k10"); push(2, 8'h01, "t3_irq_k10"); sample();
        at_after(11); rd(3'b011, 8'h01, "t3_done_k11"); push(2, 8'h01, "t3_irq_hold"); sample();
        wr_reg(3'b011, 8'h01);
        at_after(12); rd(3'b011, 8'h00, "t3_clr_k12"); push(2, 8'h00, "t3_irq_clr"); sample();
        at_after(19); rd(3'b000, 8'd1, "t3_cnt_k19"); push(2, 8'h00, "t3_irq_k19"); sample();
        at_after(20); rd(3'b000, 8'd3, "t3_reload_k20"); push(2, 8'h01, "t3_irq_reassert"); sample();
        at_after(23); rd(3'b000, 8'd3, "t3_cnt_k23"); sample();
        wr_reg(3'b100, 8'h55);
        at_after(24); rd(3'b000, 8'd2, "t5_ch0_undisturbed"); push(1, 8'h03, "t5_active_both"); sample();
        wr_reg(3'b011, 8'h01);
        at_after(25); rd(3'b011, 8'h00, "t5_clr_k25"); push(2, 8'h00, "t5_irq_k25"); sample();
        at_after(29); rd(3'b000, 8'd1, "t5_cnt_k29"); push(2, 8'h00, "t5_irq_k29"); sample();
        wr_reg(3'b011, 8'h01);
        at_after(30); rd(3'b011, 8'h01, "t5_clr_vs_terminal"); push(2, 8'h01, "t5_irq_k30"); sample();
        at_after(31); rd(3'b000, 8'd3, "t5_cnt_k31"); sample();

        // T4: mid-count CNTL freezes the channel, CNTH restarts with acc=0
        wr_reg(3'b000, 8'd5);
        at_after(32); rd(3'b000, 8'd5, "t4_frozen_k32"); push(1, 8'h03, "t4_active_k32"); sample();
        at_after(82); rd(3'b000, 8'd5, "t4_frozen_k82"); sample();
        wr_reg(3'b001, 8'd0);
        e0 = cyc;
        at_after(3); rd(3'b000, 8'd5, "t4_restart_k3"); sample();
        at_after(4); rd(3'b000, 8'd4, "t4_restart_k4"); sample();

        // T6: reset mid-count, then writes held off while rst is high
        at_after(5);
        rd(3'b000, 8'd4, "t6_cnt_pre"); push(2, 8'h01, "t6_irq_pre"); push(1, 8'h03, "t6_active_pre");
        sample();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd(3'b000, 8'h00, "t6_cnt_rst"); push(1, 8'h00, "t6_active_rst"); push(2, 8'h00, "t6_irq_rst");
        sample();
        adr = 3'b001; data = 8'hAA; wr = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd(3'b001, 8'h00, "t6_cnth_wr_in_rst"); push(1, 8'h00, "t6_active_wr_in_rst"); sample();
        adr = 3'b110; data = 8'h03; wr = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd(3'b110, 8'h00, "t6_ctrl_wr_in_rst"); sample();
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 8'h00, "t6_read_after_rst");
            sample();
        end

        // Channel 1 one-shot count 1 after reset
        wr_reg(3'b100, 8'd1);
        wr_reg(3'b101, 8'd0);
        e0 = cyc;
        at_after(3); rd(3'b100, 8'd1, "ch1_cnt_k3"); push(1, 8'h02, "ch1_active_k3"); sample();
        at_after(4); rd(3'b100, 8'd0, "ch1_cnt_k4"); push(1, 8'h00, "ch1_active_k4"); sample();
        at_after(5); rd(3'b111, 8'h01, "ch1_done"); sample();

        // T2: default parameters, 441 samples one-shot is 35795.45 clocks
        adr2 = 3'b000; data2 = 8'hB9; wr2 = 1'b1;
        @(posedge clk);
        #1;
        adr2 = 3'b001; data2 = 8'h01;
        @(posedge clk);
        #1;
        wr2 = 1'b0;
        t2_len = 0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (active2[0]) t2_len++;
            else break;
        end
        #1;
        adr2 = 3'b011;
        push(4, 8'h01, "t2_active_len");
        push(3, 8'h01, "t2_done");
        push(5, 8'h00, "t2_irq_masked");
        push(6, 8'h00, "t2_active_end");
        sample();

        sample();
        if (q.size() != 0) begin
            n_mis += q.size();
            $display("FAIL scoreboard_drain: %0d items left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
